melody_sequencer: RTL and testbench

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

---
 rtl/melody_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_melody_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// melody_sequencer
//   Plays a fixed 16-entry melody ROM as a sequence of tones for a square-wave
//   tone generator. Each entry sounds for len beats, followed by a short silent
//   gap. A play button toggles play/pause, a stop button aborts, and loop_en
//   makes the song repeat.
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   play_pb  in   one-cycle pulse: start (IDLE) or toggle pause (NOTE/GAP/PAUSE)
//   stop_pb  in   one-cycle pulse: abort to IDLE (wins over play_pb)
//   loop_en  in   level: restart at entry 0 after the last entry
//   note_div out  half-period count for the tone generator, 0 = silence
//   note_on  out  high while a non-rest note sounds
//   note_idx out  current ROM index
//   busy     out  high in NOTE, GAP and PAUSE
//   done     out  one-cycle pulse when the song ends with loop_en low
module melody_sequencer #(
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int SONG_LEN    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play_pb,
  input  logic        stop_pb,
  input  logic        loop_en,
  output logic [17:0] note_div,
  output logic        note_on,
  output logic [3:0]  note_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, NOTE, GAP, PAUSE} state_t;

  localparam logic [27:0] BEAT     = 28'(BEAT_CYCLES);
  localparam logic [27:0] GAP_LAST = 28'(GAP_CYCLES - 1);
  localparam logic [3:0]  LAST_IDX = 4'(SONG_LEN - 1);

  // ROM entry layout: {code[3:0], len[2:0]}
  function automatic logic [6:0] rom_word(input logic [3:0] idx);
    case (idx)
      4'd0:  rom_word = {4'd3, 3'd1};
      4'd1:  rom_word = {4'd2, 3'd1};
      4'd2:  rom_word = {4'd1, 3'd1};
      4'd3:  rom_word = {4'd2, 3'd1};
      4'd4:  rom_word = {4'd3, 3'd1};
      4'd5:  rom_word = {4'd3, 3'd1};
      4'd6:  rom_word = {4'd3, 3'd2};
      4'd7:  rom_word = {4'd2, 3'd1};
      4'd8:  rom_word = {4'd2, 3'd1};
      4'd9:  rom_word = {4'd2, 3'd2};
      4'd10: rom_word = {4'd3, 3'd1};
      4'd11: rom_word = {4'd5, 3'd1};
      4'd12: rom_word = {4'd5, 3'd2};
      4'd13: rom_word = {4'd0, 3'd1};
      4'd14: rom_word = {4'd1, 3'd2};
      default: rom_word = {4'd0, 3'd1};
    endcase
  endfunction

  function automatic logic [17:0] code_div(input logic [3:0] code);
    case (code)
      4'd1:    code_div = 18'd191110;
      4'd2:    code_div = 18'd170265;
      4'd3:    code_div = 18'd151685;
      4'd4:    code_div = 18'd143172;
      4'd5:    code_div = 18'd127551;
      4'd6:    code_div = 18'd113636;
      4'd7:    code_div = 18'd101239;
      default: code_div = 18'd0;   // rest and unused codes
    endcase
  endfunction

  state_t      state_reg, state_next;
  state_t      saved_reg, saved_next;
  logic [3:0]  idx_reg, idx_next;
  logic [27:0] cnt_reg, cnt_next;
  logic        done_next;
  logic [17:0] div_next;

  logic [6:0]  cur_entry, next_entry;
  logic [2:0]  cur_len;
  logic [27:0] note_last;

  assign cur_entry  = rom_word(idx_reg);
  assign next_entry = rom_word(idx_next);
  assign cur_len    = (cur_entry[2:0] == 3'd0) ? 3'd1 : cur_entry[2:0];
  assign note_last  = 28'(cur_len) * BEAT - 28'd1;

  // Next-state logic. The last cycle of NOTE or GAP always advances, so a
  // play_pb landing on it is ignored. When pausing, the counter still steps
  // past the cycle that was just played; on resume the next cycle continues
  // from there, so the total sounding/gap time is unchanged.
  always_comb begin
    state_next = state_reg;
    saved_next = saved_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    if (stop_pb) begin
      state_next = IDLE;
      idx_next   = 4'd0;
      cnt_next   = 28'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (play_pb) begin
            state_next = NOTE;
            idx_next   = 4'd0;
            cnt_next   = 28'd0;
          end
        end
        NOTE: begin
          if (cnt_reg == note_last) begin
            state_next = GAP;
            cnt_next   = 28'd0;
          end else begin
            cnt_next = cnt_reg + 28'd1;
            if (play_pb) begin
              state_next = PAUSE;
              saved_next = NOTE;
            end
          end
        end
        GAP: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_next = 28'd0;
            if (idx_reg < LAST_IDX) begin
              idx_next   = idx_reg + 4'd1;
              state_next = NOTE;
            end else if (loop_en) begin
              idx_next   = 4'd0;
              state_next = NOTE;
            end else begin
              idx_next   = 4'd0;
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + 28'd1;
            if (play_pb) begin
              state_next = PAUSE;
              saved_next = GAP;
            end
          end
        end
        PAUSE: begin
          if (play_pb) state_next = saved_reg;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs are computed from the next state so they are registered together
  // with it and appear one cycle after the triggering button pulse.
  assign div_next = (state_next == NOTE) ? code_div(next_entry[6:3]) : 18'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      saved_reg <= NOTE;
      idx_reg   <= 4'd0;
      cnt_reg   <= 28'd0;
      note_div  <= 18'd0;
      note_on   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      saved_reg <= saved_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      note_div  <= div_next;
      note_on   <= (div_next != 18'd0);
      busy      <= (state_next != IDLE);
      done      <= done_next;
    end
  end

  assign note_idx = idx_reg;

endmodule

// File: tb/tb_melody_sequencer.sv
module tb_melody_sequencer;

  localparam int BEAT = 10;
  localparam int GAPC = 2;
  localparam int SLEN = 16;

  logic        clk, rst, play_pb, stop_pb, loop_en;
  logic [17:0] note_div;
  logic        note_on, busy, done;
  logic [3:0]  note_idx;

  melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC), .SONG_LEN(SLEN)) dut (
    .clk(clk), .rst(rst), .play_pb(play_pb), .stop_pb(stop_pb), .loop_en(loop_en),
    .note_div(note_div), .note_on(note_on), .note_idx(note_idx), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song as written in the melody sheet: note code and beat length per entry.
  int rom_code [16] = '{3, 2, 1, 2, 3, 3, 3, 2, 2, 2, 3, 5, 5, 0, 1, 0};
  int rom_len  [16] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 2, 1, 1, 2, 1, 2, 1};
  int div_tab  [16] = '{0, 191110, 170265, 151685, 143172, 127551, 113636, 101239,
                        0, 0, 0, 0, 0, 0, 0, 0};

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference player: tracks whether a song is active, paused, in a note or
  // a gap, which entry, and how many cycles of the current phase remain.
  bit act_m, pause_m, gap_m, done_m;
  int idx_m, remain_m;
  int busy_cnt, done_cnt;

  function automatic int note_cycles(input int i);
    return ((rom_len[i] == 0) ? 1 : rom_len[i]) * BEAT;
  endfunction

  task automatic model_reset();
    act_m = 0; pause_m = 0; gap_m = 0; done_m = 0; idx_m = 0; remain_m = 0;
  endtask

  task automatic model_step(input bit p, input bit s, input bit l);
    done_m = 0;
    if (s) begin
      act_m = 0; pause_m = 0; idx_m = 0;
    end else if (!act_m) begin
      if (p) begin act_m = 1; idx_m = 0; gap_m = 0; remain_m = note_cycles(0); end
    end else if (pause_m) begin
      if (p) pause_m = 0;
    end else begin
      remain_m--;
      if (remain_m == 0) begin
        if (!gap_m) begin
          gap_m = 1; remain_m = GAPC;
        end else if (idx_m < SLEN - 1) begin
          idx_m++; gap_m = 0; remain_m = note_cycles(idx_m);
        end else if (l) begin
          idx_m = 0; gap_m = 0; remain_m = note_cycles(0);
        end else begin
          act_m = 0; idx_m = 0; done_m = 1;
        end
      end else if (p) begin
        pause_m = 1;
      end
    end
  endtask

  task automatic compare_all();
    int ed;
    ed = (act_m && !pause_m && !gap_m) ? div_tab[rom_code[idx_m]] : 0;
    check("note_div", 32'(note_div), 32'(ed));
    check("note_on",  32'(note_on),  32'(ed != 0));
    check("note_idx", 32'(note_idx), 32'(idx_m));
    check("busy",     32'(busy),     32'(act_m));
    check("done",     32'(done),     32'(done_m));
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic cycle(input bit p, input bit s, input bit l);
    play_pb = p; stop_pb = s; loop_en = l;
    @(posedge clk);
    model_step(p, s, l);
    @(negedge clk);
    compare_all();
    play_pb = 0; stop_pb = 0;
  endtask

  int total_song;
  int cnt;

  initial begin
    rst = 1; play_pb = 0; stop_pb = 0; loop_en = 0;
    model_reset();
    total_song = 0;
    for (int i = 0; i < SLEN; i++) total_song += note_cycles(i) + GAPC;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_div", 32'(note_div), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_idx", 32'(note_idx), 0);
    rst = 0;
    repeat (5) cycle(0, 0, 0);   // nothing sounds without play

    // First note timing, then the whole song without loop
    busy_cnt = 0; done_cnt = 0;
    cycle(1, 0, 0);
    check("first_div", 32'(note_div), 151685);
    check("first_on", 32'(note_on), 1);
    for (int i = 0; i < BEAT - 1; i++) begin
      cycle(0, 0, 0);
      check("hold_div", 32'(note_div), 151685);
    end
    for (int i = 0; i < GAPC; i++) begin
      cycle(0, 0, 0);
      check("gap_div", 32'(note_div), 0);
    end
    cycle(0, 0, 0);
    check("second_div", 32'(note_div), 170265);
    check("second_idx", 32'(note_idx), 1);
    for (int k = 0; k < 1000 && done_cnt == 0; k++) cycle(0, 0, 0);
    check("song_cycles", 32'(busy_cnt), 32'(total_song));
    repeat (3) cycle(0, 0, 0);
    check("done_pulses", 32'(done_cnt), 1);
    check("end_idx", 32'(note_idx), 0);
    check("end_busy", 32'(busy), 0);

    // Pause for 50 cycles after 4 cycles of entry 6, then resume
    cycle(1, 0, 0);
    for (int k = 0; k < 500 && !(idx_m == 6 && !gap_m); k++) cycle(0, 0, 0);
    repeat (3) cycle(0, 0, 0);
    cycle(1, 0, 0);
    check("pause_busy", 32'(busy), 1);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(0, 0, 0);
      if (note_on) cnt++;
    end
    check("pause_note_on", 32'(cnt), 0);
    cycle(1, 0, 0);
    cnt = (note_on && note_idx == 6) ? 1 : 0;
    for (int k = 0; k < 100; k++) begin
      cycle(0, 0, 0);
      if (note_on && note_idx == 6) cnt++;
      else break;
    end
    check("resume_len", 32'(cnt), 16);
    cycle(0, 1, 0);

    // Looping; also a play press on the final gap cycle of entry 0
    done_cnt = 0;
    cycle(1, 0, 1);
    for (int k = 0; k < 100 && !(gap_m && remain_m == 1); k++) cycle(0, 0, 1);
    cycle(1, 0, 1);
    check("late_play_idx", 32'(note_idx), 1);
    check("late_play_div", 32'(note_div), 170265);
    for (int k = 0; k < 1000 && !(idx_m == 15 && gap_m); k++) cycle(0, 0, 1);
    for (int k = 0; k < 100 && idx_m != 0; k++) cycle(0, 0, 1);
    check("wrap_idx", 32'(note_idx), 0);
    check("wrap_div", 32'(note_div), 151685);
    check("wrap_no_done", 32'(done_cnt), 0);

    // Stop and play in the same cycle during a note
    repeat (3) cycle(0, 0, 1);
    cycle(1, 1, 1);
    check("stop_div", 32'(note_div), 0);
    check("stop_on", 32'(note_on), 0);
    check("stop_busy", 32'(busy), 0);
    check("stop_idx", 32'(note_idx), 0);

    // Asynchronous reset mid-note
    cycle(1, 0, 0);
    repeat (4) cycle(0, 0, 0);
    #1 rst = 1;
    #1;
    check("arst_div", 32'(note_div), 0);
    check("arst_on", 32'(note_on), 0);
    check("arst_busy", 32'(busy), 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    repeat (3) cycle(0, 0, 0);

    // Random button traffic against the reference player
    loop_en = 0;
    for (int k = 0; k < 4000; k++) begin
      bit lp;
      lp = ((k / 700) % 2) == 1;
      cycle($urandom_range(0, 24) == 0, $urandom_range(0, 299) == 0, lp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
